// File: rtl/iomem_decoder.sv
// iomem_decoder: registered address decoder between the picosoc iomem bus
// and up to NUM_SLOTS memory-mapped peripheral slots.
//
// Each CPU request is latched and forwarded to exactly one slot, chosen by
// address. The decoder then waits for that slot's ready pulse and answers
// the CPU with a single-cycle iomem_ready. An access outside the decoded
// window is answered at once with zero data and sets a sticky error flag.
//
// Optional feature macro: IOMEM_DECODER_TIMEOUT_EN
//   Defined     : a 16-bit REQ-cycle counter aborts an access to a silent
//                 slot after TIMEOUT cycles. The CPU receives 32'hFFFF_FFFF
//                 and err_timeout is set.
//   Not defined : REQ waits for the slot indefinitely, no counter is built,
//                 and err_timeout is tied low.

module iomem_decoder #(
    parameter int          NUM_SLOTS  = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
    parameter int          SLOT_SHIFT = 8,
    parameter int          TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      iomem_valid,
    input  logic [3:0]                iomem_wstrb,
    input  logic [31:0]               iomem_addr,
    input  logic [31:0]               iomem_wdata,
    output logic [31:0]               iomem_rdata,
    output logic                      iomem_ready,
    output logic [NUM_SLOTS-1:0]      slot_valid,
    output logic [3:0]                slot_wstrb,
    output logic [31:0]               slot_addr,
    output logic [31:0]               slot_wdata,
    input  logic [32*NUM_SLOTS-1:0]   slot_rdata,
    input  logic [NUM_SLOTS-1:0]      slot_ready,
    input  logic                      err_clear,
    output logic                      err_unmapped,
    output logic                      err_timeout
);

    // Slot index width; a single-slot decoder still uses one index bit.
    localparam int IDXW    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    // Address bits at and above this position must match BASE_ADDR.
    localparam int TAG_LSB = SLOT_SHIFT + IDXW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                 state_q,      state_d;
    logic [NUM_SLOTS-1:0]   slot_valid_q, slot_valid_d;
    logic [31:0]            addr_q,       addr_d;
    logic [31:0]            wdata_q,      wdata_d;
    logic [3:0]             wstrb_q,      wstrb_d;
    logic [31:0]            rdata_q,      rdata_d;
    logic                   ready_q,      ready_d;
    logic                   err_unm_q,    err_unm_d;

`ifdef IOMEM_DECODER_TIMEOUT_EN
    // Counter value at which the current REQ cycle is the last one allowed.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0]            cnt_q,        cnt_d;
    logic                   err_to_q,     err_to_d;
`endif

    // Decode of the incoming CPU address.
    logic [IDXW-1:0]        req_idx_s;
    logic                   tag_match_s;
    logic                   idx_in_range_s;
    logic                   hit_s;
    logic [NUM_SLOTS-1:0]   req_onehot_s;

    // Response from the slot currently being served.
    logic                   sel_ready_s;
    logic [31:0]            sel_rdata_s;

    assign req_idx_s      = iomem_addr[SLOT_SHIFT +: IDXW];
    assign tag_match_s    = ((iomem_addr >> TAG_LSB) == (BASE_ADDR >> TAG_LSB));
    assign idx_in_range_s = (32'(req_idx_s) < 32'(NUM_SLOTS));
    assign hit_s          = tag_match_s && idx_in_range_s;

    // One-hot slot request built from the decoded index.
    always_comb begin
        req_onehot_s = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            req_onehot_s[k] = (req_idx_s == IDXW'(k));
        end
    end

    // Pick the served slot's ready and data. slot_valid_q is one-hot while
    // in REQ, so masking with it ignores every unselected slot.
    always_comb begin
        sel_ready_s = |(slot_ready & slot_valid_q);
        sel_rdata_s = 32'h0000_0000;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            sel_rdata_s = sel_rdata_s | (slot_rdata[32*k +: 32] & {32{slot_valid_q[k]}});
        end
    end

    // Next-state and next-output computation for the decoder FSM.
    always_comb begin
        state_d      = state_q;
        slot_valid_d = slot_valid_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        rdata_d      = rdata_q;
        ready_d      = ready_q;
`ifdef IOMEM_DECODER_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif

        // A clear request is applied first so that a new error set below wins.
        if (err_clear) begin
            err_unm_d = 1'b0;
        end else begin
            err_unm_d = err_unm_q;
        end
`ifdef IOMEM_DECODER_TIMEOUT_EN
        if (err_clear) begin
            err_to_d = 1'b0;
        end else begin
            err_to_d = err_to_q;
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (iomem_valid && !ready_q) begin
                    addr_d  = iomem_addr;
                    wdata_d = iomem_wdata;
                    wstrb_d = iomem_wstrb;
                    if (hit_s) begin
                        slot_valid_d = req_onehot_s;
`ifdef IOMEM_DECODER_TIMEOUT_EN
                        cnt_d        = 16'h0000;
`endif
                        state_d      = ST_REQ;
                    end else begin
                        // Unmapped: answer immediately so the CPU never stalls.
                        rdata_d   = 32'h0000_0000;
                        err_unm_d = 1'b1;
                        ready_d   = 1'b1;
                        state_d   = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_REQ: begin
                if (sel_ready_s) begin
                    // Drop slot_valid on the edge that samples ready, so the
                    // peripheral cannot see the access a second time.
                    rdata_d      = sel_rdata_s;
                    slot_valid_d = '0;
                    ready_d      = 1'b1;
                    state_d      = ST_RESP;
                end else begin
`ifdef IOMEM_DECODER_TIMEOUT_EN
                    if (cnt_q == TO_LAST) begin
                        rdata_d      = 32'hFFFF_FFFF;
                        slot_valid_d = '0;
                        err_to_d     = 1'b1;
                        ready_d      = 1'b1;
                        cnt_d        = cnt_q + 16'h0001;
                        state_d      = ST_RESP;
                    end else begin
                        cnt_d   = cnt_q + 16'h0001;
                        state_d = ST_REQ;
                    end
`else
                    state_d = ST_REQ;
`endif
                end
            end

            ST_RESP: begin
                ready_d = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                slot_valid_d = '0;
                ready_d      = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            slot_valid_q <= '0;
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 32'h0000_0000;
            wstrb_q      <= 4'h0;
            rdata_q      <= 32'h0000_0000;
            ready_q      <= 1'b0;
            err_unm_q    <= 1'b0;
`ifdef IOMEM_DECODER_TIMEOUT_EN
            cnt_q        <= 16'h0000;
            err_to_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            slot_valid_q <= slot_valid_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rdata_q      <= rdata_d;
            ready_q      <= ready_d;
            err_unm_q    <= err_unm_d;
`ifdef IOMEM_DECODER_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_to_q     <= err_to_d;
`endif
        end
    end

    assign iomem_rdata  = rdata_q;
    assign iomem_ready  = ready_q;
    assign slot_valid   = slot_valid_q;
    assign slot_addr    = addr_q;
    assign slot_wdata   = wdata_q;
    assign slot_wstrb   = wstrb_q;
    assign err_unmapped = err_unm_q;
`ifdef IOMEM_DECODER_TIMEOUT_EN
    assign err_timeout  = err_to_q;
`else
    assign err_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_iomem_decoder.sv
// Self-checking bench for iomem_decoder.
// Peripheral slots are modelled as responders with a configurable latency,
// optional spurious ready, and optional silence. Expected values come from
// an address-range reference model: hit = BASE <= addr < BASE + NS*256.

module tb_iomem_decoder;

    localparam int          NS   = 4;
    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam int          TO   = 10;

    logic              clk;
    logic              resetn;
    logic              iomem_valid;
    logic [3:0]        iomem_wstrb;
    logic [31:0]       iomem_addr;
    logic [31:0]       iomem_wdata;
    logic [31:0]       iomem_rdata;
    logic              iomem_ready;
    logic [NS-1:0]     slot_valid;
    logic [3:0]        slot_wstrb;
    logic [31:0]       slot_addr;
    logic [31:0]       slot_wdata;
    logic [32*NS-1:0]  slot_rdata;
    logic [NS-1:0]     slot_ready;
    logic              err_clear;
    logic              err_unmapped;
    logic              err_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // Peripheral model configuration. A latency of 0 means the slot is silent.
    int          lat_cfg [NS];
    bit          spur    [NS];
    logic [31:0] sdata   [NS];
    int          seen    [NS];
    bit          mon_en = 1'b0;

    // Expected sticky error flags.
    logic exp_unm;
    logic exp_to;

    iomem_decoder #(
        .NUM_SLOTS (NS),
        .BASE_ADDR (BASE),
        .SLOT_SHIFT(8),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .iomem_ready (iomem_ready),
        .slot_valid  (slot_valid),
        .slot_wstrb  (slot_wstrb),
        .slot_addr   (slot_addr),
        .slot_wdata  (slot_wdata),
        .slot_rdata  (slot_rdata),
        .slot_ready  (slot_ready),
        .err_clear   (err_clear),
        .err_unmapped(err_unmapped),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NS; g++) begin : g_rdata
        assign slot_rdata[32*g +: 32] = sdata[g];
    end

    // Reference model: address-range decode.
    function automatic bit m_hit(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(NS * 256));
    endfunction

    function automatic int m_slot(input logic [31:0] a);
        return int'((a - BASE) / 32'd256);
    endfunction

    // Peripheral responders: each pulses ready lat_cfg cycles after it first sees valid.
    always @(negedge clk) begin
        for (int k = 0; k < NS; k++) begin
            logic rdy;
            rdy = spur[k];
            if (slot_valid[k] === 1'b1) begin
                seen[k] = seen[k] + 1;
                if (lat_cfg[k] != 0 && seen[k] == lat_cfg[k] + 1) rdy = 1'b1;
            end else begin
                seen[k] = 0;
            end
            slot_ready[k] = rdy;
        end
    end

    // slot_valid must always be one-hot or all-zero.
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (!$onehot0(slot_valid)) begin
                n_bad++;
                $display("FAIL onehot slot_valid=%b required one-hot or zero", slot_valid);
            end
        end
    end

    // One CPU access: drive the request, wait for iomem_ready, then release the bus.
    task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata,
                          output int lat, output int sv_cycles, output logic [NS-1:0] sv_seen);
        bit done;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wdata = wdata;
        iomem_wstrb = wstrb;
        lat = 0; sv_cycles = 0; sv_seen = '0; rdata = 32'h0; done = 1'b0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (slot_valid !== '0) begin
                sv_cycles++;
                sv_seen = sv_seen | slot_valid;
            end
            if (iomem_ready === 1'b1) begin
                rdata = iomem_rdata;
                done  = 1'b1;
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL access_wait addr=%h no iomem_ready within 200 cycles", addr);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (iomem_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_pulse addr=%h iomem_ready=%b required 0 after pulse", addr, iomem_ready);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; iomem_valid = 1'b0; iomem_addr = 32'h0; iomem_wdata = 32'h0;
        iomem_wstrb = 4'h0; err_clear = 1'b0;
        for (int k = 0; k < NS; k++) begin
            lat_cfg[k] = 1; spur[k] = 1'b0; sdata[k] = 32'h0; seen[k] = 0;
        end
        exp_unm = 1'b0; exp_to = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({slot_valid, iomem_ready, err_unmapped, err_timeout} !== '0) begin
            n_bad++;
            $display("FAIL reset_ctrl valid=%b ready=%b unm=%b to=%b required all 0",
                     slot_valid, iomem_ready, err_unmapped, err_timeout);
        end
        n_cmp++;
        if ({iomem_rdata, slot_addr, slot_wdata, slot_wstrb} !== '0) begin
            n_bad++;
            $display("FAIL reset_data rdata=%h addr=%h wdata=%h wstrb=%h required 0",
                     iomem_rdata, slot_addr, slot_wdata, slot_wstrb);
        end
        @(negedge clk);
        resetn = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_write();
        logic [31:0] rd; int lat, svc; logic [NS-1:0] svs;
        lat_cfg[0] = 1;
        access(32'h0200_0000, 32'h0000_0003, 4'hF, rd, lat, svc, svs);
        n_cmp++;
        if (lat != 3) begin n_bad++; $display("FAIL write_latency got %0d required 3", lat); end
        n_cmp++;
        if (svc != 2 || svs !== 4'b0001) begin
            n_bad++; $display("FAIL write_slot_valid cycles=%0d seen=%b required 2/0001", svc, svs);
        end
        n_cmp++;
        if (slot_wdata !== 32'h3 || slot_wstrb !== 4'hF || slot_addr !== 32'h0200_0000) begin
            n_bad++;
            $display("FAIL write_latch wdata=%h wstrb=%h addr=%h required 3/F/02000000",
                     slot_wdata, slot_wstrb, slot_addr);
        end
    endtask

    task automatic test_spurious();
        logic [31:0] rd; int lat, svc; logic [NS-1:0] svs;
        lat_cfg[1] = 2; sdata[1] = 32'hA5A5_0001; spur[0] = 1'b1;
        access(32'h0200_0104, 32'h0, 4'h0, rd, lat, svc, svs);
        spur[0] = 1'b0;
        n_cmp++;
        if (rd !== 32'hA5A5_0001) begin n_bad++; $display("FAIL spurious_rdata got %h required a5a50001", rd); end
        n_cmp++;
        if (svs !== 4'b0010 || lat != 4) begin
            n_bad++; $display("FAIL spurious_select seen=%b lat=%0d required 0010/4", svs, lat);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd; int lat, svc; logic [NS-1:0] svs;
        sdata[0] = 32'h1234_5678;
        access(32'h0300_0000, 32'h0, 4'h0, rd, lat, svc, svs);
        exp_unm = 1'b1;
        n_cmp++;
        if (lat != 1 || rd !== 32'h0 || svs !== '0) begin
            n_bad++; $display("FAIL unmapped_resp lat=%0d rdata=%h seen=%b required 1/0/0", lat, rd, svs);
        end
        n_cmp++;
        if (err_unmapped !== 1'b1) begin n_bad++; $display("FAIL unmapped_flag got %b required 1", err_unmapped); end
        @(negedge clk); err_clear = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (err_unmapped !== 1'b0) begin n_bad++; $display("FAIL err_clear got %b required 0", err_unmapped); end
        @(negedge clk); err_clear = 1'b0;
        exp_unm = 1'b0;
    endtask

    task automatic test_clear_vs_set();
        @(negedge clk);
        iomem_valid = 1'b1; iomem_addr = 32'h0300_0010; iomem_wstrb = 4'h0; err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0; iomem_valid = 1'b0;
        n_cmp++;
        if (err_unmapped !== 1'b1 || iomem_ready !== 1'b1) begin
            n_bad++; $display("FAIL clear_vs_set unm=%b ready=%b required 1/1", err_unmapped, iomem_ready);
        end
        exp_unm = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int n; bit done;
        lat_cfg[3] = 1; sdata[3] = $urandom;
        @(negedge clk);
        iomem_valid = 1'b1; iomem_addr = 32'h0400_0000; iomem_wstrb = 4'h0;
        @(posedge clk); #1;
        n_cmp++;
        if (iomem_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_first ready=%b required 1", iomem_ready); end
        iomem_addr = BASE + 32'h0000_0300;
        @(posedge clk); #1;
        n_cmp++;
        if (slot_valid !== '0) begin n_bad++; $display("FAIL b2b_early_accept slot_valid=%b required 0", slot_valid); end
        n = 0; done = 1'b0;
        while (!done && n < 20) begin
            @(posedge clk); #1; n++;
            if (iomem_ready === 1'b1) begin
                done = 1'b1;
                n_cmp++;
                if (n != 3 || iomem_rdata !== sdata[3]) begin
                    n_bad++; $display("FAIL b2b_second n=%0d rdata=%h required 3/%h", n, iomem_rdata, sdata[3]);
                end
            end
        end
        iomem_valid = 1'b0;
        if (!done) begin n_cmp++; n_bad++; $display("FAIL b2b_wait no ready within 20 cycles"); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lat, svc; logic [NS-1:0] svs; bit quiet;
        lat_cfg[2] = 3; sdata[2] = $urandom;
        @(negedge clk);
        iomem_valid = 1'b1; iomem_addr = BASE + 32'h0000_0208; iomem_wdata = 32'hDEAD_BEEF; iomem_wstrb = 4'h3;
        @(posedge clk); #1;
        n_cmp++;
        if (slot_valid !== 4'b0100) begin n_bad++; $display("FAIL midrst_req slot_valid=%b required 0100", slot_valid); end
        @(negedge clk); resetn = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (slot_valid !== '0 || iomem_ready !== 1'b0 || err_unmapped !== 1'b0 || slot_addr !== 32'h0) begin
            n_bad++; $display("FAIL midrst_clear valid=%b ready=%b unm=%b addr=%h required 0",
                              slot_valid, iomem_ready, err_unmapped, slot_addr);
        end
        exp_unm = 1'b0; exp_to = 1'b0;
        @(negedge clk); iomem_valid = 1'b0; resetn = 1'b1;
        quiet = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (iomem_ready !== 1'b0 || slot_valid !== '0) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin n_bad++; $display("FAIL midrst_abort aborted access completed after reset"); end
        access(BASE + 32'h0000_0208, 32'h0, 4'h0, rd, lat, svc, svs);
        n_cmp++;
        if (rd !== sdata[2] || lat != 5) begin
            n_bad++; $display("FAIL midrst_fresh rdata=%h lat=%0d required %h/5", rd, lat, sdata[2]);
        end
    endtask

`ifdef IOMEM_DECODER_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] rd; int lat, svc; logic [NS-1:0] svs;
        lat_cfg[2] = 0;
        access(BASE + 32'h0000_0200, 32'h0, 4'h0, rd, lat, svc, svs);
        exp_to = 1'b1;
        n_cmp++;
        if (lat != TO + 1 || rd !== 32'hFFFF_FFFF || svc != TO) begin
            n_bad++; $display("FAIL timeout_resp lat=%0d rdata=%h svc=%0d required %0d/ffffffff/%0d",
                              lat, rd, svc, TO + 1, TO);
        end
        n_cmp++;
        if (err_timeout !== 1'b1 || slot_valid !== '0) begin
            n_bad++; $display("FAIL timeout_flag to=%b valid=%b required 1/0", err_timeout, slot_valid);
        end
        // Ready arriving on the final allowed REQ cycle must win over the timeout.
        lat_cfg[2] = TO - 1; sdata[2] = $urandom;
        access(BASE + 32'h0000_0200, 32'h0, 4'h0, rd, lat, svc, svs);
        n_cmp++;
        if (lat != TO + 1 || rd !== sdata[2]) begin
            n_bad++; $display("FAIL timeout_race lat=%0d rdata=%h required %0d/%h", lat, rd, TO + 1, sdata[2]);
        end
        lat_cfg[2] = 1;
    endtask
`endif

    task automatic test_random();
        logic [31:0] a, wd, rd; logic [3:0] ws; int lat, svc, tgt; logic [NS-1:0] svs;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0:       a = $urandom;
                1:       a = ($urandom_range(0, 1) == 0) ? (BASE - 32'd4) : (BASE + 32'(NS * 256));
                default: a = BASE + 32'($urandom_range(0, NS - 1) * 256) + ($urandom_range(0, 255) & 32'hFC);
            endcase
            wd = $urandom; ws = 4'($urandom);
            tgt = m_hit(a) ? m_slot(a) : -1;
            for (int k = 0; k < NS; k++) begin
                lat_cfg[k] = $urandom_range(1, 4);
                sdata[k]   = $urandom;
                spur[k]    = (k != tgt) && ($urandom_range(0, 2) == 0);
            end
            access(a, wd, ws, rd, lat, svc, svs);
            for (int k = 0; k < NS; k++) spur[k] = 1'b0;
            if (tgt < 0) exp_unm = 1'b1;
            n_cmp++;
            if (tgt >= 0) begin
                if (rd !== sdata[tgt] || lat != lat_cfg[tgt] + 2 || svc != lat_cfg[tgt] + 1 ||
                    svs !== NS'(1 << tgt)) begin
                    n_bad++;
                    $display("FAIL rand_hit it=%0d addr=%h rdata=%h lat=%0d svc=%0d seen=%b required %h/%0d/%0d/slot%0d",
                             it, a, rd, lat, svc, svs, sdata[tgt], lat_cfg[tgt] + 2, lat_cfg[tgt] + 1, tgt);
                end
            end else begin
                if (rd !== 32'h0 || lat != 1 || svs !== '0) begin
                    n_bad++;
                    $display("FAIL rand_miss it=%0d addr=%h rdata=%h lat=%0d seen=%b required 0/1/0",
                             it, a, rd, lat, svs);
                end
            end
            n_cmp++;
            if (slot_addr !== a || slot_wdata !== wd || slot_wstrb !== ws) begin
                n_bad++; $display("FAIL rand_latch it=%0d addr=%h wdata=%h wstrb=%h required %h/%h/%h",
                                  it, slot_addr, slot_wdata, slot_wstrb, a, wd, ws);
            end
            n_cmp++;
            if (err_unmapped !== exp_unm || err_timeout !== exp_to) begin
                n_bad++; $display("FAIL rand_flags it=%0d unm=%b to=%b required %b/%b",
                                  it, err_unmapped, err_timeout, exp_unm, exp_to);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_spurious();
        test_unmapped();
        test_clear_vs_set();
        test_back_to_back();
        test_reset_mid();
`ifdef IOMEM_DECODER_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
